sd_bus_arbiter: RTL and testbench

//  Owns the shared SD-card SPI lines (sd_cs, sd_mosi) and sequences the init, sector-write and

---
 rtl/sd_bus_arbiter_if.sv | 43 ++++
 rtl/sd_bus_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_sd_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_bus_arbiter_if.sv
// Signal bundle between the SD SPI arbiter, its user request ports and the init/write/read engines.
// The arbiter uses the master view; the surrounding logic (or a testbench) uses the slave view.
interface sd_bus_arbiter_if;
  logic        sd_cs;
  logic        sd_mosi;
  logic        init_cs;
  logic        init_mosi;
  logic        init_done;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ready;
  logic        wr_ack;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_ack;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        wr_cs;
  logic        wr_mosi;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_cs;
  logic        rd_mosi;
  logic [1:0]  owner;
  logic        timeout_err;

  modport master (
    output sd_cs, sd_mosi, wr_ready, wr_ack, rd_ready, rd_ack,
           wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr, owner, timeout_err,
    input  init_cs, init_mosi, init_done, wr_req, wr_addr, rd_req, rd_addr,
           wr_busy, wr_cs, wr_mosi, rd_busy, rd_cs, rd_mosi
  );

  modport slave (
    input  sd_cs, sd_mosi, wr_ready, wr_ack, rd_ready, rd_ack,
           wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr, owner, timeout_err,
    output init_cs, init_mosi, init_done, wr_req, wr_addr, rd_req, rd_addr,
           wr_busy, wr_cs, wr_mosi, rd_busy, rd_cs, rd_mosi
  );
endinterface

// File: rtl/sd_bus_arbiter.sv
// Shares the SD-card SPI lines between the init, sector-write and sector-read engines:
// init owns the bus until init_done, then one write and one read request are served round-robin.
module sd_bus_arbiter #(
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned OP_TIMEOUT    = 1000000,
  parameter int unsigned IDLE_GAP      = 8
) (
  input logic              clk_ref,
  input logic              rstn,
  sd_bus_arbiter_if.master bus
);

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OP_LAST    = CNT_W'(OP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_RD   = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_GAP   = 3'd1,
    ST_IDLE  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_start_q, wr_start_d;
  logic             rd_start_q, rd_start_d;
  logic             wr_pend_q, wr_pend_d;
  logic             rd_pend_q, rd_pend_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic             wr_ready_q, wr_ready_d;
  logic             rd_ready_q, rd_ready_d;
  logic             wr_ack_q, wr_ack_d;
  logic             rd_ack_q, rd_ack_d;
  logic             tmo_q, tmo_d;
  logic             last_rd_q, last_rd_d;
  logic             busy_sel;

  assign busy_sel = (owner_q == OWN_WR) ? bus.wr_busy : bus.rd_busy;

  // Next-state, request capture and grant logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    wr_start_d = wr_start_q;
    rd_start_d = rd_start_q;
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    tmo_d      = 1'b0;
    last_rd_d  = last_rd_q;

    if (bus.wr_req && wr_ready_q) begin
      wr_pend_d = 1'b1;
      wr_addr_d = bus.wr_addr;
    end
    if (bus.rd_req && rd_ready_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.rd_addr;
    end

    case (state_q)
      ST_INIT: begin
        owner_d = OWN_INIT;
        if (bus.init_done) begin
          state_d = ST_GAP;
          owner_d = OWN_NONE;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        // A request accepted this cycle may be granted in the same cycle.
        if (wr_pend_d && (!rd_pend_d || last_rd_q)) begin
          state_d    = ST_START;
          owner_d    = OWN_WR;
          wr_start_d = 1'b1;
          last_rd_d  = 1'b0;
          cnt_d      = '0;
        end else if (rd_pend_d) begin
          state_d    = ST_START;
          owner_d    = OWN_RD;
          rd_start_d = 1'b1;
          last_rd_d  = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_START: begin
        if (busy_sel) begin
          state_d    = ST_RUN;
          wr_start_d = 1'b0;
          rd_start_d = 1'b0;
          cnt_d      = '0;
        end else if (cnt_q == START_LAST) begin
          state_d    = ST_GAP;
          owner_d    = OWN_NONE;
          wr_start_d = 1'b0;
          rd_start_d = 1'b0;
          tmo_d      = 1'b1;
          cnt_d      = '0;
          if (owner_q == OWN_WR) wr_pend_d = 1'b0;
          else                   rd_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Entry required busy high, so the first low sample is the falling edge.
        if (!busy_sel) begin
          state_d = ST_GAP;
          owner_d = OWN_NONE;
          cnt_d   = '0;
          if (owner_q == OWN_WR) begin
            wr_ack_d  = 1'b1;
            wr_pend_d = 1'b0;
          end else begin
            rd_ack_d  = 1'b1;
            rd_pend_d = 1'b0;
          end
        end else if (cnt_q == OP_LAST) begin
          state_d = ST_GAP;
          owner_d = OWN_NONE;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          if (owner_q == OWN_WR) wr_pend_d = 1'b0;
          else                   rd_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        owner_d = OWN_INIT;
        cnt_d   = '0;
      end
    endcase

    // Losing the card drops everything back to the init engine.
    if ((state_q != ST_INIT) && !bus.init_done) begin
      state_d    = ST_INIT;
      owner_d    = OWN_INIT;
      cnt_d      = '0;
      wr_start_d = 1'b0;
      rd_start_d = 1'b0;
      wr_pend_d  = 1'b0;
      rd_pend_d  = 1'b0;
      wr_ack_d   = 1'b0;
      rd_ack_d   = 1'b0;
      tmo_d      = 1'b0;
    end

    wr_ready_d = (state_d != ST_INIT) && !wr_pend_d;
    rd_ready_d = (state_d != ST_INIT) && !rd_pend_d;
  end

  always_ff @(posedge clk_ref or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_INIT;
      owner_q    <= OWN_INIT;
      cnt_q      <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      tmo_q      <= 1'b0;
      last_rd_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      tmo_q      <= tmo_d;
      last_rd_q  <= last_rd_d;
    end
  end

  // SPI line mux, driven from the registered owner; an unowned bus is parked high.
  always_comb begin
    bus.sd_cs   = 1'b1;
    bus.sd_mosi = 1'b1;
    case (owner_q)
      OWN_INIT: begin bus.sd_cs = bus.init_cs; bus.sd_mosi = bus.init_mosi; end
      OWN_WR:   begin bus.sd_cs = bus.wr_cs;   bus.sd_mosi = bus.wr_mosi;   end
      OWN_RD:   begin bus.sd_cs = bus.rd_cs;   bus.sd_mosi = bus.rd_mosi;   end
      default:  ;
    endcase
  end

  assign bus.owner       = owner_q;
  assign bus.wr_start_en = wr_start_q;
  assign bus.rd_start_en = rd_start_q;
  assign bus.wr_sec_addr = wr_addr_q;
  assign bus.rd_sec_addr = rd_addr_q;
  assign bus.wr_ready    = wr_ready_q;
  assign bus.rd_ready    = rd_ready_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.rd_ack      = rd_ack_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Bench for sd_bus_arbiter: randomized requests and engine timing, checked against
// expectations derived from the arbitration rules (round-robin order, gap and timeout cycle counts).
module tb_sd_bus_arbiter;

  localparam int START_TO = 64;
  localparam int OP_TO    = 200;
  localparam int GAP      = 8;

  logic clk_ref;
  logic rstn;
  int   cyc;
  int   n_chk;
  int   n_err;
  bit   last_rd;

  sd_bus_arbiter_if bus();

  sd_bus_arbiter #(
    .START_TIMEOUT (START_TO),
    .OP_TIMEOUT    (OP_TO),
    .IDLE_GAP      (GAP)
  ) dut (
    .clk_ref (clk_ref),
    .rstn    (rstn),
    .bus     (bus)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: requests are single-cycle pulses, engine SPI lines get fresh random values.
  task automatic step();
    @(posedge clk_ref);
    #1;
    cyc++;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.init_cs   = 1'($urandom);
    bus.init_mosi = 1'($urandom);
    bus.wr_cs     = 1'($urandom);
    bus.wr_mosi   = 1'($urandom);
    bus.rd_cs     = 1'($urandom);
    bus.rd_mosi   = 1'($urandom);
    #1;
  endtask

  function automatic logic start_of(input bit w);
    return w ? bus.wr_start_en : bus.rd_start_en;
  endfunction

  function automatic logic ack_of(input bit w);
    return w ? bus.wr_ack : bus.rd_ack;
  endfunction

  function automatic logic ready_of(input bit w);
    return w ? bus.wr_ready : bus.rd_ready;
  endfunction

  task automatic set_busy(input bit w, input logic v);
    if (w) bus.wr_busy = v;
    else   bus.rd_busy = v;
  endtask

  task automatic chk_mux(input string tag, input int own);
    logic [1:0] e;
    case (own)
      1:       e = {bus.init_cs, bus.init_mosi};
      2:       e = {bus.wr_cs, bus.wr_mosi};
      3:       e = {bus.rd_cs, bus.rd_mosi};
      default: e = 2'b11;
    endcase
    chk(tag, 32'({bus.sd_cs, bus.sd_mosi}), 32'(e));
  endtask

  // Waits (bounded) for a start level and checks which engine got it and when.
  task automatic wait_start(input bit is_wr, input int exp_cyc, input string tag);
    int n;
    n = 0;
    while (!(bus.wr_start_en || bus.rd_start_en) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_grant"}, 32'({bus.wr_start_en, bus.rd_start_en}), is_wr ? 32'd2 : 32'd1);
    chk({tag, "_when"}, 32'(cyc), 32'(exp_cyc));
  endtask

  // Engine model for one granted op, called on the first cycle start_en is seen high.
  // mode 0: busy after d cycles for len cycles; 1: never busy; 2: busy stuck high.
  task automatic serve(input bit is_wr, input logic [31:0] addr, input int d, input int len,
                       input int mode, output int end_cyc);
    int own;
    own = is_wr ? 2 : 3;
    chk("sec_addr", is_wr ? bus.wr_sec_addr : bus.rd_sec_addr, addr);
    chk("owner_op", 32'(bus.owner), 32'(own));
    chk_mux("mux_op", own);
    if (mode == 1) begin
      repeat (START_TO - 1) step();
      chk("start_held", 32'(start_of(is_wr)), 32'd1);
      chk("start_no_err", 32'(bus.timeout_err), 32'd0);
      step();
      chk("start_to_drop", 32'(start_of(is_wr)), 32'd0);
      chk("start_to_err", 32'(bus.timeout_err), 32'd1);
      chk("start_to_owner", 32'(bus.owner), 32'd0);
      chk("start_to_noack", 32'({bus.wr_ack, bus.rd_ack}), 32'd0);
      chk("start_to_ready", 32'(ready_of(is_wr)), 32'd1);
    end else begin
      repeat (d) step();
      chk("start_until_busy", 32'(start_of(is_wr)), 32'd1);
      set_busy(is_wr, 1'b1);
      step();
      chk("start_drop", 32'(start_of(is_wr)), 32'd0);
      chk_mux("mux_run", own);
      if (mode == 2) begin
        repeat (OP_TO - 1) step();
        chk("op_to_early", 32'(bus.timeout_err), 32'd0);
        step();
        chk("op_to_err", 32'(bus.timeout_err), 32'd1);
        chk("op_to_owner", 32'(bus.owner), 32'd0);
        chk_mux("op_to_park", 0);
        chk("op_to_noack", 32'({bus.wr_ack, bus.rd_ack}), 32'd0);
        set_busy(is_wr, 1'b0);
      end else begin
        repeat (len - 1) step();
        chk("ack_early", 32'(ack_of(is_wr)), 32'd0);
        set_busy(is_wr, 1'b0);
        step();
        chk("ack", 32'(ack_of(is_wr)), 32'd1);
        chk("ack_owner", 32'(bus.owner), 32'd0);
        chk("ack_ready", 32'(ready_of(is_wr)), 32'd1);
      end
    end
    end_cyc = cyc;
    step();
    chk("pulse_1cyc", 32'({bus.wr_ack, bus.rd_ack, bus.timeout_err}), 32'd0);
  endtask

  initial begin
    int         kind, d0, l0, d1, l1, s, e;
    bit         first_wr;
    logic [31:0] wa, ra;
    logic       quiet;

    n_chk = 0; n_err = 0; cyc = 0; last_rd = 1'b1;
    rstn = 1'b0;
    bus.init_done = 1'b0; bus.init_cs = 1'b1; bus.init_mosi = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_busy = 1'b0; bus.wr_cs = 1'b1; bus.wr_mosi = 1'b1;
    bus.rd_busy = 1'b0; bus.rd_cs = 1'b1; bus.rd_mosi = 1'b1;
    repeat (3) step();

    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_ready", 32'({bus.wr_ready, bus.rd_ready}), 32'd0);
    chk("rst_start", 32'({bus.wr_start_en, bus.rd_start_en}), 32'd0);
    chk("rst_addr", bus.wr_sec_addr | bus.rd_sec_addr, 32'd0);
    chk("rst_pulses", 32'({bus.wr_ack, bus.rd_ack, bus.timeout_err}), 32'd0);
    rstn = 1'b1;

    // Init engine owns the bus; requests are not accepted.
    for (int i = 0; i < 6; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = $urandom;
      step();
      chk_mux("init_mux", 1);
      chk("init_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("init_no_start", 32'({bus.wr_start_en, bus.rd_start_en}), 32'd0);
    end
    bus.init_done = 1'b1;
    step();
    chk("gap_owner", 32'(bus.owner), 32'd0);
    chk_mux("gap_park", 0);
    chk("ready_after_init", 32'({bus.wr_ready, bus.rd_ready}), 32'd3);
    repeat (GAP + 2) step();

    // Rounds: 0=write only, 1=read only, 2=both; round-robin decides pair order.
    for (int r = 0; r < 8; r++) begin
      if (r == 0)      kind = 0;
      else if (r == 1) kind = 1;
      else if (r < 4)  kind = 2;
      else             kind = int'($urandom_range(0, 2));
      wa = (r == 0) ? 32'h0000_1234 : $urandom;
      ra = $urandom;
      d0 = (r == 0) ? 3   : int'($urandom_range(1, 8));
      l0 = (r == 0) ? 100 : int'($urandom_range(1, 40));
      d1 = int'($urandom_range(1, 8));
      l1 = int'($urandom_range(1, 40));
      if (kind != 1) begin bus.wr_req = 1'b1; bus.wr_addr = wa; end
      if (kind != 0) begin bus.rd_req = 1'b1; bus.rd_addr = ra; end
      first_wr = (kind == 0) || ((kind == 2) && last_rd);
      s = cyc;
      step();
      wait_start(first_wr, s + 1, "grant1");
      last_rd = !first_wr;
      if (r == 0) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = 32'hDEAD_BEEF;
        chk("wr_ready_busy", 32'(bus.wr_ready), 32'd0);
      end
      serve(first_wr, first_wr ? wa : ra, d0, l0, 0, e);
      if (r == 0) chk("wr_addr_held", bus.wr_sec_addr, 32'h0000_1234);
      if (kind == 2) begin
        wait_start(!first_wr, e + GAP + 1, "grant2");
        last_rd = first_wr;
        serve(!first_wr, first_wr ? ra : wa, d1, l1, 0, e);
      end
      repeat (GAP + 2) step();
    end

    // Write engine never answers: start timeout.
    wa = $urandom;
    bus.wr_req = 1'b1; bus.wr_addr = wa;
    s = cyc;
    step();
    wait_start(1'b1, s + 1, "sto_grant");
    last_rd = 1'b0;
    serve(1'b1, wa, 0, 0, 1, e);
    repeat (GAP + 2) step();

    // Read engine stays busy: op timeout, bus parked.
    ra = $urandom;
    bus.rd_req = 1'b1; bus.rd_addr = ra;
    s = cyc;
    step();
    wait_start(1'b0, s + 1, "oto_grant");
    last_rd = 1'b1;
    serve(1'b0, ra, int'($urandom_range(1, 5)), 0, 2, e);
    repeat (GAP + 2) step();

    // Card lost mid-op with the other request pending.
    bus.wr_req = 1'b1; bus.wr_addr = $urandom;
    bus.rd_req = 1'b1; bus.rd_addr = $urandom;
    first_wr = last_rd;
    s = cyc;
    step();
    wait_start(first_wr, s + 1, "drop_grant");
    last_rd = !first_wr;
    step();
    set_busy(first_wr, 1'b1);
    repeat (3) step();
    chk("drop_running", 32'(bus.owner), first_wr ? 32'd2 : 32'd3);
    bus.init_done = 1'b0;
    step();
    chk("drop_owner", 32'(bus.owner), 32'd1);
    chk_mux("drop_mux", 1);
    chk("drop_start", 32'({bus.wr_start_en, bus.rd_start_en}), 32'd0);
    chk("drop_ready", 32'({bus.wr_ready, bus.rd_ready}), 32'd0);
    chk("drop_pulses", 32'({bus.wr_ack, bus.rd_ack, bus.timeout_err}), 32'd0);
    set_busy(first_wr, 1'b0);
    step();
    chk("drop_noack", 32'({bus.wr_ack, bus.rd_ack, bus.timeout_err}), 32'd0);
    bus.init_done = 1'b1;
    step();
    chk("reinit_owner", 32'(bus.owner), 32'd0);
    chk("reinit_pend_clear", 32'({bus.wr_ready, bus.rd_ready}), 32'd3);
    quiet = 1'b0;
    repeat (3 * GAP) begin
      step();
      quiet = quiet | bus.wr_start_en | bus.rd_start_en;
    end
    chk("no_stale_grant", 32'(quiet), 32'd0);

    // Asynchronous reset in the middle of a write.
    wa = $urandom | 32'h1;
    bus.wr_req = 1'b1; bus.wr_addr = wa;
    s = cyc;
    step();
    wait_start(1'b1, s + 1, "rst_grant");
    step();
    bus.wr_busy = 1'b1;
    repeat (3) step();
    rstn = 1'b0;
    #1;
    chk("mid_rst_owner", 32'(bus.owner), 32'd1);
    chk("mid_rst_start", 32'({bus.wr_start_en, bus.rd_start_en}), 32'd0);
    chk("mid_rst_addr", bus.wr_sec_addr, 32'd0);
    chk("mid_rst_ready", 32'({bus.wr_ready, bus.rd_ready}), 32'd0);
    bus.wr_busy = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_gap", 32'(bus.owner), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
